tx_rom_serializer: RTL and testbench

- Controller and serializer that sits directly downstream of the transmit ROM.
- On a start pulse it reads NUM_WORDS words from the ROM at addresses 0 to NUM_WORDS-1, using the ROM's registered 1-cycle read.
- It shifts each word out MSB-first as a synchronous bit stream with a qualifying valid strobe.
- It drives the ROM's address and read inputs and consumes the ROM's data output.

---
 rtl/tx_rom_serializer.sv | 131 +++++++++++++
 tb/tb_tx_rom_serializer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/tx_rom_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tx_rom_serializer
// Purpose  : Fetches NUM_WORDS words from a 1-cycle registered ROM and sends
//            them MSB-first as a serial stream. Optional macro: TX_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tx_rom_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2,
  parameter int NUM_WORDS  = 2**ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  rom_read,
  input  logic [DATA_WIDTH-1:0] rom_q,
  output logic                  tx_bit,
  output logic                  tx_valid,
  output logic                  word_start,
  output logic                  busy,
  output logic                  done
);

`ifdef TX_PARITY_EN
  localparam int c_BITS = DATA_WIDTH + 1;
`else
  localparam int c_BITS = DATA_WIDTH;
`endif
  localparam int                  c_CW        = $clog2(c_BITS + 1);
  localparam logic [c_CW-1:0]     c_LAST      = c_CW'(c_BITS - 1);
  localparam logic [ADDR_WIDTH-1:0] c_ADDR_LAST = ADDR_WIDTH'(NUM_WORDS - 1);
`ifdef TX_PARITY_EN
  localparam logic [c_CW-1:0]     c_DLAST     = c_CW'(DATA_WIDTH - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_shreg;
  logic [c_CW-1:0]       r_cnt;
`ifdef TX_PARITY_EN
  logic                  r_parity;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_shreg    <= '0;
      r_cnt      <= '0;
`ifdef TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
      rom_addr   <= '0;
      rom_read   <= 1'b0;
      tx_bit     <= 1'b0;
      tx_valid   <= 1'b0;
      word_start <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state  <= S_FETCH;
            rom_read <= 1'b1;
            rom_addr <= '0;
            busy     <= 1'b1;
          end
        end
        S_FETCH: begin
          rom_read <= 1'b0;
          r_state  <= S_LOAD;
        end
        S_LOAD: begin
          // MSB goes straight to the output register so it appears on the first SHIFT cycle
          tx_bit     <= rom_q[DATA_WIDTH-1];
          r_shreg    <= rom_q << 1;
          tx_valid   <= 1'b1;
          word_start <= 1'b1;
          r_cnt      <= '0;
`ifdef TX_PARITY_EN
          r_parity   <= ^rom_q;
`endif
          r_state    <= S_SHIFT;
        end
        S_SHIFT: begin
          word_start <= 1'b0;
          r_cnt      <= r_cnt + 1'b1;
          if (r_cnt == c_LAST) begin
            tx_valid <= 1'b0;
            tx_bit   <= 1'b0;
            if (rom_addr == c_ADDR_LAST) begin
              r_state  <= S_DONE;
              done     <= 1'b1;
              busy     <= 1'b0;
              rom_addr <= '0;
            end else begin
              rom_addr <= rom_addr + 1'b1;
              rom_read <= 1'b1;
              r_state  <= S_FETCH;
            end
          end
`ifdef TX_PARITY_EN
          else if (r_cnt == c_DLAST) begin
            tx_bit <= r_parity;
          end
`endif
          else begin
            tx_bit  <= r_shreg[DATA_WIDTH-1];
            r_shreg <= r_shreg << 1;
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tx_rom_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_rom_serializer
// Purpose  : Cycle-level scoreboard bench for tx_rom_serializer (4-word and 1-word builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tx_rom_serializer;

`ifdef TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int WP = 8 + 2 + P;
  localparam int FL = 4 * WP;

  // {rom_read, rom_addr[1:0], tx_valid, tx_bit, word_start, busy, done}
  typedef logic [7:0] obs_t;

  logic clk = 1'b0;
  logic reset, start0, start1;
  logic [1:0] rom_addr0, rom_addr1;
  logic rom_read0, rom_read1;
  logic [7:0] rom_q0, rom_q1;
  logic tx_bit0, tx_valid0, word_start0, busy0, done0;
  logic tx_bit1, tx_valid1, word_start1, busy1, done1;

  logic [7:0] rom0 [4];
  logic [7:0] rom1 [4];

  obs_t q0[$];
  obs_t q1[$];
  int n_checks = 0;
  int n_err = 0;
  int cycle = 0;
  int done0_cnt = 0;
  int rd1_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (rom_read0) rom_q0 <= rom0[rom_addr0];
  always @(posedge clk) if (rom_read1) rom_q1 <= rom1[rom_addr1];

  tx_rom_serializer #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .NUM_WORDS(4)) u_dut0 (
    .clk(clk), .reset(reset), .start(start0), .rom_addr(rom_addr0),
    .rom_read(rom_read0), .rom_q(rom_q0), .tx_bit(tx_bit0), .tx_valid(tx_valid0),
    .word_start(word_start0), .busy(busy0), .done(done0));

  tx_rom_serializer #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .NUM_WORDS(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .rom_addr(rom_addr1),
    .rom_read(rom_read1), .rom_q(rom_q1), .tx_bit(tx_bit1), .tx_valid(tx_valid1),
    .word_start(word_start1), .busy(busy1), .done(done1));

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cycle);
    end
  endtask

  function automatic obs_t pack(input logic rd, input logic [1:0] a, input logic v,
                                input logic b, input logic ws, input logic bz, input logic dn);
    return {rd, a, v, b, ws, bz, dn};
  endfunction

  task automatic push(input int which, input obs_t e);
    if (which == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  // Expected outputs for every cycle from the FETCH after start through DONE
  task automatic push_frame(input int which, input int nw);
    logic [7:0] word;
    logic [1:0] a;
    for (int w = 0; w < nw; w++) begin
      word = (which == 0) ? rom0[w] : rom1[w];
      a = 2'(w);
      push(which, pack(1'b1, a, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
      push(which, pack(1'b0, a, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
      for (int i = 0; i < 8; i++)
        push(which, pack(1'b0, a, 1'b1, word[7-i], (i == 0), 1'b1, 1'b0));
      if (P == 1)
        push(which, pack(1'b0, a, 1'b1, ^word, 1'b0, 1'b1, 1'b0));
    end
    push(which, pack(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
  endtask

  task automatic monitor();
    obs_t e0, e1;
    cycle++;
    e0 = (q0.size() > 0) ? q0.pop_front() : '0;
    e1 = (q1.size() > 0) ? q1.pop_front() : '0;
    check("dut0_outputs", {24'd0, rom_read0, rom_addr0, tx_valid0, tx_bit0, word_start0, busy0, done0}, {24'd0, e0});
    check("dut1_outputs", {24'd0, rom_read1, rom_addr1, tx_valid1, tx_bit1, word_start1, busy1, done1}, {24'd0, e1});
    if (done0 === 1'b1) done0_cnt++;
    if (rom_read1 === 1'b1) rd1_cnt++;
  endtask

  // Sample at the falling edge, then move inputs just after it
  task automatic step();
    @(negedge clk);
    monitor();
    #1;
  endtask

  task automatic wait_drain(input int max);
    int i;
    for (i = 0; i < max; i++) begin
      if (q0.size() == 0 && q1.size() == 0) break;
      step();
    end
    if (i == max) check("drain_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int d, r;
    rom0[0] = 8'hA5; rom0[1] = 8'h3C; rom0[2] = 8'hFF;
`ifdef TX_PARITY_EN
    rom0[3] = 8'h01;
`else
    rom0[3] = 8'h00;
`endif
    rom1[0] = 8'h81; rom1[1] = 8'h00; rom1[2] = 8'h00; rom1[3] = 8'h00;

    reset = 1'b1; start0 = 1'b0; start1 = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    step();

    // single start pulse, full frame
    start0 = 1'b1; push_frame(0, 4);
    step();
    start0 = 1'b0;
    wait_drain(200);
    repeat (3) step();

    // start held through the frame, re-pulsed in DONE, then again in first IDLE cycle
    d = done0_cnt;
    start0 = 1'b1; push_frame(0, 4);
    repeat (FL) step();
    start0 = 1'b0;
    step();
    start0 = 1'b1;
    step();
    push_frame(0, 4);
    step();
    start0 = 1'b0;
    wait_drain(200);
    repeat (3) step();
    check("held_start_frames", 32'(done0_cnt - d), 32'd2);

    // reset during the 4th bit of word 1
    d = done0_cnt;
    start0 = 1'b1; push_frame(0, 4);
    step();
    start0 = 1'b0;
    repeat (WP + 5) step();
    reset = 1'b1; q0.delete();
    step();
    reset = 1'b0;
    repeat (4) step();
    check("reset_no_done", 32'(done0_cnt - d), 32'd0);
    start0 = 1'b1; push_frame(0, 4);
    step();
    start0 = 1'b0;
    wait_drain(200);
    repeat (3) step();

    // one-word instance
    r = rd1_cnt;
    start1 = 1'b1; push_frame(1, 1);
    step();
    start1 = 1'b0;
    wait_drain(100);
    repeat (3) step();
    check("dut1_rom_reads", 32'(rd1_cnt - r), 32'd1);

    // start together with reset in IDLE
    reset = 1'b1; start0 = 1'b1; start1 = 1'b1;
    repeat (3) step();
    reset = 1'b0; start0 = 1'b0; start1 = 1'b0;
    repeat (5) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
